// File: rtl/punit_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : punit_mdu_pkg
// Brief    : Shared encodings for the processing unit: ALU opcodes, writeback
//            source selects, MDU operation codes and MDU sequencer states.
// Revision : 1.0  initial release
// ============================================================================
package punit_mdu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADC  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SBC  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_ANDN = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_ROL  = 4'd10,
        ALU_ROR  = 4'd11,
        ALU_PASS = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'd0,
        MUX_DATA = 2'd1,
        MUX_PORT = 2'd2,
        MUX_MDU  = 2'd3
    } regmux_e;

    typedef enum logic [1:0] {
        MOP_MULL = 2'd0,
        MOP_MULH = 2'd1,
        MOP_DIVQ = 2'd2,
        MOP_DIVR = 2'd3
    } mop_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/punit_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : punit_mdu_seq
// Brief    : Bit-serial multiply/divide unit. Shift-add multiply and restoring
//            divide, one bit per enabled cycle, sharing one hi/lo register pair.
// Revision : 1.0  initial release
// ============================================================================
module punit_mdu_seq
    import punit_mdu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic [1:0]        mop_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output logic              c_o
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q, hi_q, lo_q, res_q;
    mop_e              mop_q;
    logic              dz_q, c_q;

    logic              accept, last, is_div;
    logic [DATA_W:0]   sum, trial, diff;
    logic [DATA_W-1:0] hi_d, lo_d, res_d;
    logic              c_d;

    assign accept = (state_q == MDU_IDLE) && en_i && start_i;
    assign is_div = (mop_q == MOP_DIVQ) || (mop_q == MOP_DIVR);
    // Divide by zero short-circuits after a single RUN cycle.
    assign last   = dz_q || (cnt_q == CNT_W'(DATA_W - 1));

    // One iteration of the serial datapath plus result/carry selection.
    always_comb begin
        sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        trial = {hi_q, lo_q[DATA_W-1]};
        diff  = trial - {1'b0, b_q};
        hi_d  = '0;
        lo_d  = '0;
        if (is_div) begin
            // A clear borrow bit means the trial remainder covers the divisor.
            if (!diff[DATA_W]) begin
                hi_d = diff[DATA_W-1:0];
                lo_d = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
                hi_d = trial[DATA_W-1:0];
                lo_d = {lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[DATA_W:1];
            lo_d = {sum[0], lo_q[DATA_W-1:1]};
        end
        res_d = '0;
        if (dz_q) begin
            res_d = (mop_q == MOP_DIVQ) ? '1 : a_q;
        end else begin
            case (mop_q)
                MOP_MULL: res_d = lo_d;
                MOP_MULH: res_d = hi_d;
                MOP_DIVQ: res_d = lo_d;
                default:  res_d = hi_d;
            endcase
        end
        c_d = is_div ? dz_q : (hi_d != '0);
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept) state_d = MDU_RUN;
            MDU_RUN:  if (en_i && last) state_d = MDU_DONE;
            MDU_DONE: if (en_i) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MDU_IDLE;
        else       state_q <= state_d;
    end

    // Operand latch, serial iteration and result capture at completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
            mop_q <= MOP_MULL;
            dz_q  <= 1'b0;
            c_q   <= 1'b0;
        end else if (en_i) begin
            if (accept) begin
                a_q   <= a_i;
                b_q   <= b_i;
                mop_q <= mop_e'(mop_i);
                dz_q  <= mop_i[1] && (b_i == '0);
                cnt_q <= '0;
                hi_q  <= '0;
                lo_q  <= mop_i[1] ? a_i : b_i;
            end else if (state_q == MDU_RUN) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) begin
                    res_q <= res_d;
                    c_q   <= c_d;
                end
            end
        end
    end

    assign busy_o = (state_q == MDU_RUN);
    assign done_o = (state_q == MDU_DONE);
    assign res_o  = res_q;
    assign c_o    = c_q;

endmodule
`default_nettype wire

// File: rtl/punit_mdu.sv
`default_nettype none
// ============================================================================
// Module   : punit_mdu
// Brief    : Processing unit slice: register file, ALU with carry/zero flags
//            and interrupt shadow, plus a bit-serial multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
module punit_mdu
    import punit_mdu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ClkEn_i,
    input  logic [$clog2(NREG)-1:0]     rs_i,
    input  logic [$clog2(NREG)-1:0]     rs2_i,
    input  logic [$clog2(NREG)-1:0]     rd_i,
    input  logic [DATA_W-1:0]           immed_i,
    input  logic [$clog2(DATA_W)-1:0]   count_i,
    input  logic                        op2_c_i,
    input  logic [3:0]                  ALUOp_c_i,
    input  logic [1:0]                  RegMux_c_i,
    input  logic [DATA_W-1:0]           data_dat_i,
    input  logic [DATA_W-1:0]           port_data_i,
    input  logic                        RegWrt_c_i,
    input  logic                        ALUFR_c_i,
    input  logic                        int_c_i,
    input  logic                        reti_c_i,
    input  logic                        start_i,
    input  logic [1:0]                  mop_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [DATA_W-1:0]           res_o,
    output logic [DATA_W-1:0]           mdu_o,
    output logic                        ccC_o,
    output logic                        ccZ_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              c_q, z_q, cs_q, zs_q;

    logic [DATA_W-1:0] op1, op2, alu_res, wb_data, mdu_res;
    logic              alu_c, alu_z, mdu_c, mdu_done;

    assign op1 = regs_q[rs_i];
    assign op2 = op2_c_i ? immed_i : regs_q[rs2_i];

    // ALU: result and carry for the selected operation.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (alu_op_e'(ALUOp_c_i))
            ALU_ADD:  {alu_c, alu_res} = {1'b0, op1} + {1'b0, op2};
            ALU_ADC:  {alu_c, alu_res} = {1'b0, op1} + {1'b0, op2} + (DATA_W+1)'(c_q);
            ALU_SUB:  {alu_c, alu_res} = {1'b0, op1} - {1'b0, op2};
            ALU_SBC:  {alu_c, alu_res} = {1'b0, op1} - {1'b0, op2} - (DATA_W+1)'(c_q);
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_ANDN: alu_res = op1 & ~op2;
            // The extra bit beyond the word catches the last bit shifted out.
            ALU_SHL:  {alu_c, alu_res} = {1'b0, op1} << count_i;
            ALU_SHR:  {alu_res, alu_c} = {op1, 1'b0} >> count_i;
            ALU_ROL: begin
                alu_res = (op1 << count_i) | (op1 >> (DATA_W - int'(count_i)));
                alu_c   = (count_i != '0) && alu_res[0];
            end
            ALU_ROR: begin
                alu_res = (op1 >> count_i) | (op1 << (DATA_W - int'(count_i)));
                alu_c   = (count_i != '0) && alu_res[DATA_W-1];
            end
            default:  alu_res = op2;
        endcase
    end

    assign alu_z = (alu_res == '0);

    // Writeback source select.
    always_comb begin
        case (regmux_e'(RegMux_c_i))
            MUX_ALU:  wb_data = alu_res;
            MUX_DATA: wb_data = data_dat_i;
            MUX_PORT: wb_data = port_data_i;
            default:  wb_data = mdu_res;
        endcase
    end

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (ClkEn_i && RegWrt_c_i && (rd_i != '0)) begin
            regs_q[rd_i] <= wb_data;
        end
    end

    // Live flags and interrupt shadow; restore beats MDU beats ALU load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_q  <= 1'b0;
            z_q  <= 1'b0;
            cs_q <= 1'b0;
            zs_q <= 1'b0;
        end else if (ClkEn_i) begin
            if (int_c_i) begin
                cs_q <= c_q;
                zs_q <= z_q;
            end
            if (reti_c_i) begin
                c_q <= cs_q;
                z_q <= zs_q;
            end else if (mdu_done) begin
                c_q <= mdu_c;
                z_q <= (mdu_res == '0);
            end else if (ALUFR_c_i) begin
                c_q <= alu_c;
                z_q <= alu_z;
            end
        end
    end

    punit_mdu_seq #(
        .DATA_W (DATA_W)
    ) u_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (ClkEn_i),
        .start_i (start_i),
        .mop_i   (mop_i),
        .a_i     (op1),
        .b_i     (op2),
        .busy_o  (busy_o),
        .done_o  (mdu_done),
        .res_o   (mdu_res),
        .c_o     (mdu_c)
    );

    assign done_o = mdu_done;
    assign res_o  = alu_res;
    assign mdu_o  = mdu_res;
    assign ccC_o  = c_q;
    assign ccZ_o  = z_q;

endmodule
`default_nettype wire

// File: tb/tb_punit_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_punit_mdu
// Brief    : Self-checking bench for punit_mdu with a queue-based scoreboard
//            for MDU results and an arithmetic reference model for the ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_punit_mdu;

    localparam int          W = 8;
    localparam int unsigned M = 255;

    logic       clk_i = 1'b0, rst_i, ClkEn_i;
    logic [2:0] rs_i, rs2_i, rd_i, count_i;
    logic [7:0] immed_i, data_dat_i, port_data_i;
    logic       op2_c_i, RegWrt_c_i, ALUFR_c_i, int_c_i, reti_c_i, start_i;
    logic [3:0] ALUOp_c_i;
    logic [1:0] RegMux_c_i, mop_i;
    logic       busy_o, done_o, ccC_o, ccZ_o;
    logic [7:0] res_o, mdu_o;

    punit_mdu #(.DATA_W(8), .NREG(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ClkEn_i(ClkEn_i),
        .rs_i(rs_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .immed_i(immed_i), .count_i(count_i), .op2_c_i(op2_c_i),
        .ALUOp_c_i(ALUOp_c_i), .RegMux_c_i(RegMux_c_i),
        .data_dat_i(data_dat_i), .port_data_i(port_data_i),
        .RegWrt_c_i(RegWrt_c_i), .ALUFR_c_i(ALUFR_c_i),
        .int_c_i(int_c_i), .reti_c_i(reti_c_i),
        .start_i(start_i), .mop_i(mop_i),
        .busy_o(busy_o), .done_o(done_o), .res_o(res_o), .mdu_o(mdu_o),
        .ccC_o(ccC_o), .ccZ_o(ccZ_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned res;
        bit          c;
        bit          z;
        int          busy;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          busy_cnt = 0;
    int unsigned mregs[8];
    int unsigned model_mdu = 0;
    bit          mC = 0, mZ = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference ALU: plain arithmetic, shifts done one bit at a time.
    function automatic void alu_model(input int op, input int unsigned a, input int unsigned b,
                                      input int n, input bit cin,
                                      output int unsigned r, output bit c);
        c = 0;
        r = 0;
        case (op)
            0: begin r = (a + b) & M;        c = (a + b) > M;        end
            1: begin r = (a + b + cin) & M;  c = (a + b + cin) > M;  end
            2: begin r = (a - b) & M;        c = a < b;              end
            3: begin r = (a - b - cin) & M;  c = a < (b + cin);      end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = a & ~b & M;
            8, 9, 10, 11: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    if (op == 8 || op == 10) begin
                        c = r[W-1];
                        r = ((r << 1) | ((op == 10) ? int'(c) : 0)) & M;
                    end else begin
                        c = r[0];
                        r = (r >> 1) | ((op == 11) ? (int'(c) << (W-1)) : 0);
                    end
                end
            end
            default: r = b;
        endcase
    endfunction

    // Expected MDU outcome from ordinary multiply/divide.
    function automatic exp_t mdu_model(input int unsigned a, input int unsigned b, input int mop);
        exp_t        e;
        int unsigned p;
        p = a * b;
        e.busy = W;
        case (mop)
            0: begin e.res = p & M;  e.c = (p >> W) != 0; end
            1: begin e.res = p >> W; e.c = (p >> W) != 0; end
            default: begin
                if (b == 0) begin
                    e.res  = (mop == 2) ? M : a;
                    e.c    = 1;
                    e.busy = 1;
                end else begin
                    e.res = (mop == 2) ? a / b : a % b;
                    e.c   = 0;
                end
            end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Monitor: counts enabled busy cycles and checks each completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                busy_cnt = 0;
            end else if (ClkEn_i) begin
                if (busy_o) busy_cnt++;
                if (done_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("mdu_result", mdu_o, e.res);
                        check("mdu_busy_cycles", busy_cnt, e.busy);
                        busy_cnt = 0;
                        @(posedge clk_i);
                        #1;
                        check("mdu_flag_C", ccC_o, e.c);
                        check("mdu_flag_Z", ccZ_o, e.z);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        ClkEn_i = 1; rs_i = 0; rs2_i = 0; rd_i = 0; count_i = 0; immed_i = 0;
        data_dat_i = 0; port_data_i = 0; op2_c_i = 0; ALUOp_c_i = 0; RegMux_c_i = 0;
        RegWrt_c_i = 0; ALUFR_c_i = 0; int_c_i = 0; reti_c_i = 0; start_i = 0; mop_i = 0;
    endtask

    task automatic write_reg(input int rd, input int unsigned val);
        ClkEn_i = 1; RegWrt_c_i = 1; RegMux_c_i = 0; ALUOp_c_i = 4'd12; ALUFR_c_i = 0;
        op2_c_i = 1; immed_i = 8'(val); rd_i = 3'(rd);
        tick();
        RegWrt_c_i = 0;
        if (rd != 0) mregs[rd] = val & M;
    endtask

    task automatic clear_model();
        foreach (mregs[i]) mregs[i] = 0;
        model_mdu = 0; mC = 0; mZ = 0;
    endtask

    task automatic run_mdu(input int rs, input int rs2, input bit useimm, input int unsigned imm,
                           input int mop, input bit rnd);
        exp_t        e;
        int unsigned b;
        b = useimm ? imm : mregs[rs2];
        e = mdu_model(mregs[rs], b, mop);
        rs_i = 3'(rs); rs2_i = 3'(rs2); op2_c_i = useimm; immed_i = 8'(imm);
        mop_i = 2'(mop); start_i = 1; ClkEn_i = 1; RegWrt_c_i = 0; ALUFR_c_i = 0;
        sb.push_back(e);
        model_mdu = e.res; mC = e.c; mZ = e.z;
        tick();
        start_i = 0;
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            if (rnd) begin
                ClkEn_i = ($urandom_range(0, 3) != 0);
                start_i = ($urandom_range(0, 5) == 0);
                mop_i   = 2'($urandom_range(0, 3));
                rs_i    = 3'($urandom_range(0, 7));
                immed_i = 8'($urandom_range(0, 255));
            end
            tick();
        end
        if (sb.size() != 0) begin
            check("mdu_timeout", 1, 0);
            sb.delete();
        end
        start_i = 0;
        ClkEn_i = 1;
        tick();
    endtask

    initial begin
        int unsigned a, b, r;
        bit          c, en;
        int          op, n, mux, rd;

        idle_inputs();
        clear_model();
        rst_i = 1;
        repeat (2) tick();
        rst_i = 0;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_mdu", mdu_o, 0);
        check("reset_C", ccC_o, 0);
        check("reset_Z", ccZ_o, 0);
        ALUOp_c_i = 4'd12; rs2_i = 3'd3;
        #1 check("reset_reg3", res_o, 0);

        // Register 0 discards writes.
        write_reg(0, 8'h55);
        ALUOp_c_i = 4'd0; rs_i = 0; rs2_i = 0; op2_c_i = 0;
        #1 check("r0_add", res_o, 0);
        ALUOp_c_i = 4'd12;
        #1 check("r0_pass", res_o, 0);

        // start with the clock enable low is ignored.
        write_reg(1, 200);
        write_reg(2, 3);
        rs_i = 1; rs2_i = 2; op2_c_i = 0; mop_i = 0; start_i = 1; ClkEn_i = 0;
        repeat (3) tick();
        check("start_gated_busy", busy_o, 0);
        start_i = 0; ClkEn_i = 1;

        run_mdu(1, 2, 0, 0, 0, 0);
        run_mdu(1, 2, 0, 0, 1, 0);
        write_reg(1, 100);
        run_mdu(1, 0, 1, 7, 2, 0);
        run_mdu(1, 0, 1, 7, 3, 0);
        write_reg(1, 9);
        write_reg(2, 0);
        run_mdu(1, 2, 0, 0, 2, 0);

        // Interrupt shadow save coinciding with a flag load, then restore.
        write_reg(1, 200);
        ALUOp_c_i = 4'd0; rs_i = 1; op2_c_i = 1; immed_i = 100; ALUFR_c_i = 1;
        tick();
        check("irq_pre_C", ccC_o, 1);
        check("irq_pre_Z", ccZ_o, 0);
        ALUOp_c_i = 4'd4; immed_i = 0; int_c_i = 1;
        tick();
        check("irq_load_C", ccC_o, 0);
        check("irq_load_Z", ccZ_o, 1);
        ALUFR_c_i = 0; int_c_i = 0; reti_c_i = 1;
        tick();
        reti_c_i = 0;
        check("reti_C", ccC_o, 1);
        check("reti_Z", ccZ_o, 0);
        mC = 1; mZ = 0;

        // Reset in the middle of a multiply.
        write_reg(1, 200);
        write_reg(2, 3);
        rs_i = 1; rs2_i = 2; op2_c_i = 0; mop_i = 0; start_i = 1;
        tick();
        start_i = 0;
        repeat (3) tick();
        #3 rst_i = 1;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_mdu", mdu_o, 0);
        check("midrst_C", ccC_o, 0);
        tick();
        rst_i = 0;
        clear_model();
        ALUOp_c_i = 4'd12; rs2_i = 1; op2_c_i = 0;
        #1 check("midrst_reg1", res_o, 0);
        write_reg(1, 200);
        write_reg(2, 3);
        run_mdu(1, 2, 0, 0, 0, 0);

        // Randomized ALU and writeback traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            rs_i    = 3'($urandom_range(0, 7));
            rs2_i   = 3'($urandom_range(0, 7));
            rd      = $urandom_range(0, 7);
            rd_i    = 3'(rd);
            op2_c_i = $urandom_range(0, 1);
            immed_i = 8'($urandom_range(0, 255));
            op      = $urandom_range(0, 15);
            ALUOp_c_i = 4'(op);
            n       = $urandom_range(0, 7);
            count_i = 3'(n);
            mux     = $urandom_range(0, 3);
            RegMux_c_i  = 2'(mux);
            data_dat_i  = 8'($urandom_range(0, 255));
            port_data_i = 8'($urandom_range(0, 255));
            RegWrt_c_i  = $urandom_range(0, 1);
            ALUFR_c_i   = $urandom_range(0, 1);
            en          = ($urandom_range(0, 4) != 0);
            ClkEn_i     = en;
            a = mregs[rs_i];
            b = op2_c_i ? immed_i : mregs[rs2_i];
            alu_model(op, a, b, n, mC, r, c);
            @(negedge clk_i);
            check("alu_res", res_o, r);
            check("alu_flag_C", ccC_o, mC);
            check("alu_flag_Z", ccZ_o, mZ);
            tick();
            if (en) begin
                if (RegWrt_c_i && rd != 0) begin
                    case (mux)
                        0: mregs[rd] = r;
                        1: mregs[rd] = data_dat_i;
                        2: mregs[rd] = port_data_i;
                        default: mregs[rd] = model_mdu;
                    endcase
                end
                if (ALUFR_c_i) begin
                    mC = c;
                    mZ = (r == 0);
                end
            end
        end
        RegWrt_c_i = 0; ALUFR_c_i = 0; ClkEn_i = 1;

        // Randomized MDU operations with clock-enable stalls and stray starts.
        for (int it = 0; it < 20; it++) begin
            run_mdu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
                    $urandom_range(0, 3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/punit_mdu.md
PUNIT_MDU -- requirements
Module: punit_mdu

Interface
REQ-001 Parameter DATA_W, default 8, datapath width in bits (legal 8..32).
REQ-002 Parameter NREG, default 8, register count (power of two, 4..32); RA_W = log2(NREG).
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 ClkEn_i  in  1  clock enable; all state holds when low.
REQ-006 rs_i, rs2_i, rd_i  in  RA_W each  source, second source and destination register indices.
REQ-007 immed_i  in  DATA_W  immediate operand; count_i  in  log2(DATA_W)  shift/rotate count.
REQ-008 op2_c_i  in  1  selects op2: 0 = register rs2, 1 = immed_i.
REQ-009 ALUOp_c_i  in  4  ALU operation code.
REQ-010 RegMux_c_i  in  2  writeback source: 0 = ALU, 1 = data_dat_i, 2 = port_data_i, 3 = MDU result.
REQ-011 data_dat_i, port_data_i  in  DATA_W  memory and port read data.
REQ-012 RegWrt_c_i  in  1  register write enable; ALUFR_c_i  in  1  load ALU flags.
REQ-013 int_c_i  in  1  interrupt entry, save flags; reti_c_i  in  1  return, restore flags.
REQ-014 start_i  in  1  start MDU op; mop_i  in  2  0 = mul low, 1 = mul high, 2 = quotient, 3 = remainder.
REQ-015 busy_o  out  1  MDU running; done_o  out  1  one-cycle MDU completion pulse.
REQ-016 res_o  out  DATA_W  combinational ALU result; mdu_o  out  DATA_W  held MDU result.
REQ-017 ccC_o, ccZ_o  out  1 each  live carry and zero flags.

Function
REQ-018 Register file SHALL hold NREG x DATA_W, read combinationally, write on the clock edge when ClkEn_i and RegWrt_c_i are high; no write-through bypass.
REQ-019 Register 0 SHALL always read zero; writes to it are discarded.
REQ-020 ALU ops: 0 add, 1 add+C, 2 sub, 3 sub-C, 4 and, 5 or, 6 xor, 7 and-not, 8 shl, 9 shr, 10 rol, 11 ror (by count_i), 12-15 pass op2.
REQ-021 ALU carry = add carry-out, sub borrow, or last bit shifted/rotated out (0 for count 0 and for logic ops); zero = (result == 0).
REQ-022 MDU FSM states IDLE, RUN, DONE; start_i is accepted only in IDLE with ClkEn_i high and is ignored otherwise.
REQ-023 On acceptance the MDU SHALL latch reg[rs] as A, op2 as B, and mop_i.
REQ-024 Multiply SHALL be shift-add and divide restoring, one bit per enabled cycle; busy_o is high for exactly DATA_W enabled cycles, then DONE asserts done_o for one cycle, then IDLE.
REQ-025 Divide by zero SHALL go RUN->DONE after one cycle with quotient all-ones, remainder = A, and C set.
REQ-026 mdu_o SHALL hold the selected 2*DATA_W product half, quotient or remainder from DONE until the next completion.
REQ-027 In DONE, flags SHALL load Z = (mdu result == 0) and C = (product high nonzero for mul, div-by-zero for div, else 0).
REQ-028 Flag write priority, highest first: reti_c_i (restore shadow), MDU DONE, ALUFR_c_i.
REQ-029 int_c_i SHALL copy the pre-edge C/Z into the shadow register; when it coincides with any flag load, the shadow gets the old value and the live flags get the new one.
REQ-030 ClkEn_i low SHALL freeze the FSM, bit counter, registers and flags; done_o stays asserted while frozen in DONE.

Reset
REQ-031 rst_i SHALL immediately clear all registers, flags, the shadow, mdu_o, busy_o and done_o, and force IDLE, including mid-operation.
REQ-032 The first start_i after reset release SHALL be accepted normally.

Structure
REQ-033 A shared package SHALL hold the ALU opcode enum, the RegMux select enum, the mop enum and the MDU state enum.
REQ-034 The MDU SHALL be a separate sub-module punit_mdu_seq; the ALU and register file stay inline.

Verification (DATA_W=8, NREG=8)
REQ-035 r1=200, r2=3, start mop=0 then mop=1 -> busy 8 cycles, done pulse, mdu_o=0x58 then 0x02, C=1 on the first.
REQ-036 r1=100, immed=7, op2_c=1, mop=2 and mop=3 -> mdu_o=14 then 2, Z=0, C=0.
REQ-037 r1=9, r2=0, mop=2 -> done after 1 busy cycle, mdu_o=0xFF, C=1.
REQ-038 Write 0x55 to r0, then read rs=0 -> res_o pass/add gives 0; r0 stays 0.
REQ-039 Set C=1/Z=0, int_c_i together with ALUFR on a zero result, then reti_c_i -> live Z=1 after the load, then C=1/Z=0 restored.
REQ-040 rst_i asserted during mul cycle 4 -> busy_o=0 at once, mdu_o=0; next start completes correctly.
